// File: rtl/mul16u_arb_pkg.sv
// Shared types and the round-robin pick helper for the shared 16x16 multiplier scheduler.
package mul16u_arb_pkg;
    localparam int OP_W     = 16;
    localparam int PROD_W   = 32;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
    } mul_op_t;

    typedef struct packed {
        logic [MAX_ID_W-1:0] id;
        logic [PROD_W-1:0]   z;
    } mul_rsp_t;

    // First requesting lane after 'last', wrapping mod nReq; returns 'last' when nothing requests.
    function automatic logic [MAX_ID_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                    input logic [MAX_ID_W-1:0] last,
                                                    input int nReq);
        logic [MAX_ID_W-1:0] pick;
        logic [MAX_ID_W:0]   sum;
        logic                found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            sum = {1'b0, last} + (MAX_ID_W+1)'(i);
            if (sum >= (MAX_ID_W+1)'(nReq))
                sum = sum - (MAX_ID_W+1)'(nReq);
            if (!found && i <= nReq && req[sum[MAX_ID_W-1:0]]) begin
                pick  = sum[MAX_ID_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction
endpackage

// File: rtl/mul16u_HFD.sv
// Exact combinational 16x16 unsigned multiplier, full 32-bit product.
module mul16u_HFD (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] Z
);
    assign Z = 32'(A) * 32'(B);
endmodule

// File: rtl/mul16u_share_arb.sv
// Round-robin scheduler sharing one 16x16 multiplier among N_REQ lanes, with a
// fixed-latency pipeline and a credit-protected, in-order tagged result queue.
module mul16u_share_arb
    import mul16u_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*16-1:0]      req_a,
    input  logic [N_REQ*16-1:0]      req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [31:0]              rsp_z,
    output logic                     idle
);
    localparam int FIFO_DEPTH = MUL_LAT + 2;
    localparam int ID_W       = $clog2(N_REQ);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    logic [ID_W-1:0]    lastGrant, grantIdx;
    logic [N_REQ-1:0]   grantOh;
    logic [CNT_W-1:0]   inflight, qCount;
    logic               issueOk, accept, wrVld, pop;
    logic [MUL_LAT-1:0] vldPipe;
    mul_op_t            op0;
    logic [PROD_W-1:0]  prod0;
    mul_rsp_t           stage0Rsp, wrData;
    mul_rsp_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr, rdPtr;

    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check uses registered counts only, so a same-cycle pop frees nothing yet.
    assign issueOk  = ({1'b0, inflight} + {1'b0, qCount}) < (CNT_W+1)'(FIFO_DEPTH);
    assign grantIdx = ID_W'(rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(lastGrant), N_REQ));

    always_comb begin
        grantOh = '0;
        if (rst_n && issueOk && (|req_valid))
            grantOh[grantIdx] = 1'b1;
    end

    assign req_ready = grantOh;
    assign accept    = |(req_valid & req_ready);
    assign pop       = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= ID_W'(N_REQ - 1);
            vldPipe   <= '0;
        end else begin
            if (accept)
                lastGrant <= grantIdx;
            vldPipe[0] <= accept;
            for (int k = 1; k < MUL_LAT; k++)
                vldPipe[k] <= vldPipe[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            op0 <= '{id: MAX_ID_W'(grantIdx),
                     a:  req_a[16*grantIdx +: 16],
                     b:  req_b[16*grantIdx +: 16]};
    end

    mul16u_HFD u_mul (
        .A(op0.a),
        .B(op0.b),
        .Z(prod0)
    );

    assign stage0Rsp = '{id: op0.id, z: prod0};

    // The queue entry itself is the last of the MUL_LAT registers.
    if (MUL_LAT > 1) begin : gPipe
        mul_rsp_t rspPipe [MUL_LAT-1];
        always_ff @(posedge clk) begin
            rspPipe[0] <= stage0Rsp;
            for (int k = 1; k < MUL_LAT - 1; k++)
                rspPipe[k] <= rspPipe[k-1];
        end
        assign wrData = rspPipe[MUL_LAT-2];
    end else begin : gDirect
        assign wrData = stage0Rsp;
    end

    assign wrVld = vldPipe[MUL_LAT-1];

    always_ff @(posedge clk) begin
        if (wrVld)
            mem[wrPtr] <= wrData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            inflight <= '0;
            qCount   <= '0;
        end else begin
            if (wrVld)
                wrPtr <= ptrInc(wrPtr);
            if (pop)
                rdPtr <= ptrInc(rdPtr);
            inflight <= inflight + CNT_W'(accept) - CNT_W'(wrVld);
            qCount   <= qCount + CNT_W'(wrVld) - CNT_W'(pop);
        end
    end

    // Head fields are forced to zero when empty so reset and idle outputs read clean.
    assign rsp_valid = (qCount != '0);
    assign rsp_id    = rsp_valid ? ID_W'(mem[rdPtr].id) : '0;
    assign rsp_z     = rsp_valid ? mem[rdPtr].z : '0;
    assign idle      = (inflight == '0) && (qCount == '0);
endmodule

// File: tb/tb_mul16u_share_arb.sv
// Self-checking bench for mul16u_share_arb: cycle model of credit/round-robin plus in-order scoreboard.
module tb_mul16u_share_arb;
    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = LAT + 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*16-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_z;
    logic            idle;

    mul16u_share_arb #(.N_REQ(N), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_z(rsp_z), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] z;
        int          rdy;
    } exp_t;

    exp_t         sb[$];
    int           nTests = 0, nFail = 0, cyc = 0, mLast = N - 1, nAcc = 0;
    logic [N-1:0] accMask;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] randOp();
        case ($urandom_range(5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic setOp(input int i);
        req_a[16*i +: 16] = randOp();
        req_b[16*i +: 16] = randOp();
    endtask

    // One clock: check the model at the negedge, score handshakes, advance to posedge+1.
    task automatic step();
        logic [N-1:0] expRdy;
        exp_t         e;
        int           pick;
        @(negedge clk);
        expRdy = '0;
        if (sb.size() < DEPTH && req_valid != '0) begin
            pick = -1;
            for (int k = 1; k <= N; k++)
                if (pick < 0 && req_valid[(mLast + k) % N]) pick = (mLast + k) % N;
            expRdy[pick] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(expRdy));
        chk("rsp_valid", rsp_valid, (sb.size() > 0 && sb[0].rdy <= cyc));
        chk("idle", idle, sb.size() == 0);
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("rsp_spurious", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_z", rsp_z, e.z);
            end
        end
        accMask = req_valid & req_ready;
        for (int i = 0; i < N; i++) begin
            if (accMask[i]) begin
                e.id  = i;
                e.z   = 32'(req_a[16*i +: 16]) * 32'(req_b[16*i +: 16]);
                e.rdy = cyc + LAT + 1;
                sb.push_back(e);
                mLast = i;
                nAcc++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || !idle) && n < 200) begin
            step();
            n++;
        end
        chk("drain_done", (sb.size() == 0 && idle), 1);
    endtask

    task automatic issueOne(input int lane, input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] expZ, input string tag);
        drain();
        req_valid = '0;
        req_valid[lane] = 1'b1;
        req_a[16*lane +: 16] = a;
        req_b[16*lane +: 16] = b;
        #1 chk({tag, "_rdy"}, 64'(req_ready), 64'(1 << lane));
        step();
        req_valid = '0;
        step();
        step();
        chk({tag, "_vld"}, rsp_valid, 1);
        chk({tag, "_id"}, rsp_id, lane);
        chk({tag, "_z"}, rsp_z, expZ);
        step();
    endtask

    initial begin
        int n0;
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_idle", idle, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin from reset: lane 0 first, one grant per cycle.
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) setOp(i);
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_grant", 64'(req_ready), 64'(1 << (k % N)));
            step();
            for (int i = 0; i < N; i++) if (accMask[i]) setOp(i);
        end

        issueOne(2, 16'h1234, 16'h0010, 32'h0001_2340, "single");
        issueOne(1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "maxmax");
        issueOne(0, 16'h0000, 16'hFFFF, 32'h0000_0000, "zero");
        issueOne(3, 16'h8000, 16'h0002, 32'h0001_0000, "msb");

        // Back-pressure: queue fills at DEPTH accepts, one pop buys exactly one more.
        drain();
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) setOp(i);
        n0 = nAcc;
        repeat (6) begin
            step();
            for (int i = 0; i < N; i++) if (accMask[i]) setOp(i);
        end
        chk("bp_accepts", nAcc - n0, DEPTH);
        chk("bp_stall", 64'(req_ready), 0);
        rsp_ready = 1'b1;
        n0 = nAcc;
        step();
        rsp_ready = 1'b0;
        chk("bp_pop_noacc", nAcc - n0, 0);
        chk("bp_resume_rdy", $countones(req_ready), 1);
        n0 = nAcc;
        step();
        for (int i = 0; i < N; i++) if (accMask[i]) setOp(i);
        chk("bp_resume", nAcc - n0, 1);
        step();
        chk("bp_refill", nAcc - n0, 1);
        drain();

        // Reset with 1 queued and 2 in flight.
        rsp_ready = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) setOp(i);
        repeat (3) begin
            step();
            for (int i = 0; i < N; i++) if (accMask[i]) setOp(i);
        end
        chk("pre_rst_q", rsp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_rsp_z", rsp_z, 0);
        chk("mid_rst_idle", idle, 1);
        sb.delete();
        mLast = N - 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_idle", idle, 1);
        chk("post_rst_lane0", 64'(req_ready), 1);
        rsp_ready = 1'b1;
        repeat (4) begin
            step();
            for (int i = 0; i < N; i++) if (accMask[i]) setOp(i);
        end
        drain();

        // Random soak: lanes hold valid until accepted.
        req_valid = '0;
        for (int c = 0; c < 10000; c++) begin
            rsp_ready = ($urandom_range(3) != 0);
            #1;
            step();
            for (int i = 0; i < N; i++) begin
                if (accMask[i]) begin
                    req_valid[i] = $urandom_range(1);
                    setOp(i);
                end else if (!req_valid[i] && $urandom_range(2) == 0) begin
                    req_valid[i] = 1'b1;
                    setOp(i);
                end
            end
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/mul16u_share_arb.md
# mul16u_share_arb

Shared-multiplier scheduler that time-multiplexes one exact 16x16 unsigned multiplier among `N_REQ` requesters. It uses round-robin arbitration, a registered multiply pipeline and a tagged, back-pressurable result queue. It sits between the accelerator's requester lanes and the single `mul16u_HFD` instance, so that lanes need no private multipliers. Results are exact (`Z = A*B`, 32-bit); ordering on the result bus is issue order.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `MUL_LAT`, 2: pipeline register stages after the operand capture (1..4).
- `FIFO_DEPTH`, `MUL_LAT+2`: result queue entries (localparam, not overridable).
- `ID_W`, `$clog2(N_REQ)`: tag width (localparam).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  `N_REQ`  per-lane operation request.
- `req_ready`  out  `N_REQ`  per-lane accept; at most one bit high.
- `req_a`  in  `N_REQ*16`  lane i operand A at `[16*i +: 16]`.
- `req_b`  in  `N_REQ*16`  lane i operand B at `[16*i +: 16]`.
- `rsp_valid`  out  1  result available at queue head.
- `rsp_ready`  in  1  consumer accepts head.
- `rsp_id`  out  `ID_W`  lane index of head result.
- `rsp_z`  out  32  product of head result.
- `idle`  out  1  no op in pipeline or queue.

## Operation
- **Issue condition:** `issue_ok = (inflight + q_count) < FIFO_DEPTH`.
  - Uses registered counts only; a same-cycle pop earns no credit.
- **Arbitration:** round-robin over `req_valid`.
  - Search starts at `(last_grant+1) mod N_REQ`.
  - `req_ready[g] = issue_ok & grant_onehot[g]`.
  - `last_grant` updates only on an accepted handshake (`req_valid[g] & req_ready[g]`).
  - `last_grant` resets to `N_REQ-1`, so lane 0 has first priority.
- **Lane rules:**
  - `req_ready` depends combinationally on `req_valid`.
  - Lanes must not gate `req_valid` on `req_ready`.
  - A lane holds valid and operands stable until accepted.
- **Pipeline:**
  - On accept, `{id, a, b}` is captured into stage 0.
  - The multiplier is combinational after stage 0.
  - The product plus id advance through `MUL_LAT` valid-tagged registers.
  - The last stage writes the queue.
  - The pipeline never stalls; the credit rule guarantees queue space.
- **Counters:**
  - `inflight` increments on accept and decrements on queue write.
  - `q_count` increments on write and decrements on pop (`rsp_valid & rsp_ready`).
  - Simultaneous write and pop leave `q_count` unchanged.
- **Queue:** circular buffer with wrap-around read/write pointers (mod `FIFO_DEPTH`).
  - Head is registered: `rsp_valid = q_count != 0`.
- `idle = (inflight == 0) & (q_count == 0)`.
- **Width:** operands zero-extended; the product is full 32 bits with no truncation. `0xFFFF*0xFFFF = 0xFFFE0001`.
- **Reset** (async assert, any time, including mid-operation):
  - Pipeline valids, counters and pointers are cleared; in-flight results are discarded.
  - `last_grant = N_REQ-1`.
  - Outputs: `req_ready = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_z = 0`, `idle = 1`.
  - Reset deassertion is synchronized externally.

## Timing
- **Latency:** an accept in cycle t gives `rsp_valid = 1` in cycle t+`MUL_LAT`+1, provided the queue was empty.
- **Throughput:** one accept per cycle sustained while `rsp_ready = 1` (steady state `inflight = MUL_LAT`, `q_count <= 1`).
- **Back-pressure:** with `rsp_ready = 0`, at most `FIFO_DEPTH` accepts occur, then `req_ready` is all-zero until a pop is registered.
  - Issue resumes the cycle after the pop.
- **Head stability:** `rsp_id` and `rsp_z` are stable while `rsp_valid & !rsp_ready`.

## Structure
- **Package `mul16u_arb_pkg`:**
  - Operand width 16, product width 32.
  - `mul_op_t` `{id, a, b}` and `mul_rsp_t` `{id, z}` structs.
  - Round-robin helper function `rr_pick(req, last)`.
- **Sub-module:** one instance of the exact combinational multiplier `mul16u_HFD` (ports `A`, `B`, `Z`).
- Arbiter, pipeline and queue stay in this module; the queue is not split out.

## Test plan
- **Single request:** lane 2 requests `A=0x1234`, `B=0x0010` at t → `req_ready[2]` at t; `rsp_valid`, `rsp_id=2`, `rsp_z=0x00012340` at t+3 (`MUL_LAT=2`).
- **Round-robin:** all 4 lanes continuously valid, `rsp_ready=1` → grants 0,1,2,3,0,… one per cycle; results in the same order with matching ids.
- **Boundary values:**
  - `0xFFFF*0xFFFF` → `0xFFFE0001`.
  - `0*0xFFFF` → 0.
  - `0x8000*2` → `0x00010000`.
- **Back-pressure:** `rsp_ready=0`, all lanes valid → exactly 4 accepts, then `req_ready=0`. Raise `rsp_ready` for one cycle → exactly one pop, then one further accept the next cycle. No result is lost or duplicated.
- **Reset mid-operation:** assert `rst_n=0` with 2 ops in flight and 1 queued → outputs at reset values immediately. After release, `idle=1` and lane 0 wins first.
- **Random soak:** random valids, operands and `rsp_ready` for 10k cycles → scoreboard per lane in issue order; `req_ready` one-hot; `q_count <= FIFO_DEPTH`.
